// File: rtl/multi_fault_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_fault_recovery_ctrl
// Description : Fault recovery sequencer for a CPU datapath. A fault seen in
//               NORMAL squashes the current instruction, holds the pipeline
//               for HOLD_CYCLES, then either retries from pc_saved or, once
//               MAX_RETRY retries are used, parks in SAFE until resume_req.
//               A run of CLEAN_WINDOW fault-free NORMAL cycles forgives
//               earlier retries.
// Config      : `define FAULT_RECOVERY_LOG_EN builds the fault_status and
//               fault_count logging registers. Otherwise both outputs are 0.
// Ports       : clk, reset (sync, active-low)
//               fault_vec          - fault flags, bit 0 = highest priority
//               *_write_normal     - datapath write enables
//               pc_current/saved   - current PC / PC of faulting instruction
//               resume_req         - release from SAFE
//               *_write_out        - gated write enables
//               pc_next            - PC to load
//               insert_nop         - squash current instruction
//               retry_en/recover_cpu, resume_cpu - one-cycle pulses
//               safe_mode          - high while in SAFE
//               fault_cause        - {valid, index} of latched fault
//               retry_count        - retries consumed
//               fault_status/count - sticky fault OR / entry count
// Revision    : 1.0 - initial release
// ============================================================================
module multi_fault_recovery_ctrl #(
   parameter int NUM_FAULTS   = 4,
   parameter int PC_W         = 32,
   parameter int MAX_RETRY    = 3,
   parameter int HOLD_CYCLES  = 2,
   parameter int CLEAN_WINDOW = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_FAULTS-1:0]           fault_vec,
   input  logic                            pc_write_normal,
   input  logic                            reg_write_normal,
   input  logic                            mem_write_normal,
   input  logic [PC_W-1:0]                 pc_current,
   input  logic [PC_W-1:0]                 pc_saved,
   input  logic                            resume_req,
   output logic                            pc_write_out,
   output logic                            reg_write_out,
   output logic                            mem_write_out,
   output logic [PC_W-1:0]                 pc_next,
   output logic                            insert_nop,
   output logic                            retry_en,
   output logic                            recover_cpu,
   output logic                            resume_cpu,
   output logic                            safe_mode,
   output logic [$clog2(NUM_FAULTS):0]     fault_cause,
   output logic [3:0]                      retry_count,
   output logic [NUM_FAULTS-1:0]           fault_status,
   output logic [15:0]                     fault_count
);

   localparam int CAUSE_W = $clog2(NUM_FAULTS) + 1;

   typedef enum logic [2:0] {
      ST_NORMAL = 3'd0,
      ST_SQUASH = 3'd1,
      ST_RETRY  = 3'd2,
      ST_SAFE   = 3'd3,
      ST_RESUME = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_hold;
   logic [7:0]           r_clean;
   logic [3:0]           r_retry;
   logic [CAUSE_W-1:0]   r_cause;
   logic [CAUSE_W-1:0]   w_cause_new;
   logic                 w_any_fault;
   logic                 w_enter_squash;

   assign w_any_fault    = |fault_vec;
   assign w_enter_squash = (r_state == ST_NORMAL) && w_any_fault;

   // Scan from the top down so the lowest set index wins.
   always_comb begin
      w_cause_new = '0;
      for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
         if (fault_vec[i]) begin
            w_cause_new = CAUSE_W'(i);
            w_cause_new[CAUSE_W-1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_NORMAL;
         r_hold  <= '0;
         r_clean <= '0;
         r_retry <= '0;
         r_cause <= '0;
      end else begin
         r_state <= w_next;
         r_hold  <= (r_state == ST_SQUASH) ? r_hold + 4'd1 : 4'd0;

         // Clean-run counter only advances on fault-free NORMAL cycles.
         if ((r_state == ST_NORMAL) && !w_any_fault) begin
            if (({1'b0, r_clean} + 9'd1) >= 9'(CLEAN_WINDOW)) begin
               r_clean <= '0;
               r_retry <= '0;
            end else begin
               r_clean <= r_clean + 8'd1;
            end
         end else begin
            r_clean <= '0;
         end

         if (w_enter_squash) begin
            r_cause <= w_cause_new;
         end

         if (r_state == ST_RETRY) begin
            r_retry <= r_retry + 4'd1;
         end

         if (r_state == ST_RESUME) begin
            r_retry                <= '0;
            r_cause[CAUSE_W-1]     <= 1'b0;
         end
      end
   end

   // Outputs are fully gated while reset is held so nothing leaks out.
   always_comb begin
      w_next        = r_state;
      pc_write_out  = 1'b0;
      reg_write_out = 1'b0;
      mem_write_out = 1'b0;
      pc_next       = pc_current;
      insert_nop    = 1'b0;
      retry_en      = 1'b0;
      resume_cpu    = 1'b0;
      safe_mode     = 1'b0;
      if (!reset) begin
         w_next = ST_NORMAL;
      end else begin
         case (r_state)
            ST_NORMAL: begin
               if (w_any_fault) begin
                  insert_nop = 1'b1;
                  w_next     = ST_SQUASH;
               end else begin
                  pc_write_out  = pc_write_normal;
                  reg_write_out = reg_write_normal;
                  mem_write_out = mem_write_normal;
               end
            end
            ST_SQUASH: begin
               insert_nop = 1'b1;
               if (r_hold == 4'(HOLD_CYCLES - 1)) begin
                  w_next = (r_retry < 4'(MAX_RETRY)) ? ST_RETRY : ST_SAFE;
               end
            end
            ST_RETRY: begin
               retry_en     = 1'b1;
               pc_write_out = 1'b1;
               pc_next      = pc_saved;
               w_next       = ST_NORMAL;
            end
            ST_SAFE: begin
               safe_mode  = 1'b1;
               insert_nop = 1'b1;
               if (resume_req) begin
                  w_next = ST_RESUME;
               end
            end
            ST_RESUME: begin
               resume_cpu   = 1'b1;
               pc_write_out = 1'b1;
               pc_next      = pc_saved;
               w_next       = ST_NORMAL;
            end
            default: w_next = ST_NORMAL;
         endcase
      end
   end

   assign recover_cpu = retry_en;
   assign retry_count = r_retry;
   assign fault_cause = r_cause;

`ifdef FAULT_RECOVERY_LOG_EN
   logic [NUM_FAULTS-1:0] r_status;
   logic [15:0]           r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_status <= '0;
         r_count  <= '0;
      end else begin
         r_status <= r_status | fault_vec;
         if (w_enter_squash && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   assign fault_status = r_status;
   assign fault_count  = r_count;
`else
   assign fault_status = '0;
   assign fault_count  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/multi_fault_recovery_ctrl.md
MULTI_FAULT_RECOVERY_CTRL -- requirements
Module: multi_fault_recovery_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  - NUM_FAULTS, 4, number of fault source inputs (1..16).
  - PC_W, 32, program counter width.
  - MAX_RETRY, 3, retries permitted before safe mode (1..15).
  - HOLD_CYCLES, 2, squash duration in cycles (1..15).
  - CLEAN_WINDOW, 8, fault-free cycles in NORMAL that clear the retry count (1..255).
REQ-002 The design SHALL have one clock; reset SHALL be synchronous and active-low. Ports SHALL be, one per line:
  - clk  in  1  rising-edge clock.
  - reset  in  1  synchronous active-low reset.
  - fault_vec  in  NUM_FAULTS  fault flags; bit 0 has highest priority.
  - pc_write_normal  in  1  PC write enable from the datapath.
  - reg_write_normal  in  1  register write enable from the datapath.
  - mem_write_normal  in  1  memory write enable from the datapath.
  - pc_current  in  PC_W  current PC.
  - pc_saved  in  PC_W  PC of the faulting instruction.
  - resume_req  in  1  external release from safe mode.
  - pc_write_out, reg_write_out, mem_write_out  out  1 each  gated write enables.
  - pc_next  out  PC_W  PC to load.
  - insert_nop  out  1  squash the current instruction.
  - retry_en  out  1  retry pulse.
  - recover_cpu  out  1  retry pulse (identical to retry_en).
  - resume_cpu  out  1  resume pulse.
  - safe_mode  out  1  high while in SAFE.
  - fault_cause  out  $clog2(NUM_FAULTS)+1  latched index of the highest-priority fault; MSB is the valid flag.
  - retry_count  out  4  retries consumed.
  - fault_status  out  NUM_FAULTS  sticky OR of all faults seen.
  - fault_count  out  16  total fault entries.

Function
REQ-003 The FSM SHALL have the states NORMAL, SQUASH, RETRY, SAFE and RESUME.
REQ-004 In NORMAL with fault_vec==0:
  - the three write outputs SHALL equal their *_normal inputs;
  - pc_next SHALL equal pc_current;
  - insert_nop, retry_en, recover_cpu, resume_cpu and safe_mode SHALL be 0.
REQ-005 In NORMAL with any fault_vec bit set, in the same cycle (combinational):
  - all write outputs SHALL be 0;
  - insert_nop SHALL be 1.
  On the next edge:
  - fault_cause SHALL latch {1, lowest set index};
  - the state SHALL become SQUASH.
REQ-006 SQUASH SHALL last exactly HOLD_CYCLES cycles with all writes 0 and insert_nop=1. It SHALL then go to RETRY if retry_count<MAX_RETRY, otherwise to SAFE.
REQ-007 RETRY SHALL last one cycle, with:
  - retry_en=recover_cpu=1;
  - pc_write_out=1 and pc_next=pc_saved;
  - reg_write_out=mem_write_out=0.
  retry_count SHALL increment on exit, and the state SHALL return to NORMAL.
REQ-008 In SAFE, safe_mode=1, insert_nop=1 and all writes 0. SAFE SHALL be held until resume_req=1 is sampled, then the state SHALL go to RESUME.
REQ-009 RESUME SHALL last one cycle, with:
  - resume_cpu=1;
  - pc_write_out=1 and pc_next=pc_saved;
  - other writes 0.
  On exit, retry_count and the fault_cause valid bit SHALL clear, and the state SHALL go to NORMAL.
REQ-010 A clean-cycle counter SHALL count consecutive fault-free NORMAL cycles. On reaching CLEAN_WINDOW it SHALL clear retry_count. Any fault or any non-NORMAL state SHALL zero the counter.
REQ-011 Faults outside NORMAL SHALL NOT change the state or fault_cause. They SHALL only update fault_status.
REQ-012 resume_req outside SAFE SHALL be ignored.
REQ-013 A fault present in the cycle NORMAL is re-entered (the cycle after RETRY or RESUME) SHALL be handled per REQ-005.
REQ-014 Simultaneous faults SHALL record only the lowest index in fault_cause, and every set bit in fault_status.

Reset
REQ-015 While reset==0 at a clock edge, the block SHALL reset to:
  - state NORMAL;
  - fault_cause, retry_count, clean counter, fault_status and fault_count all 0.
REQ-016 During reset cycles, all write outputs and pulses SHALL be 0 and pc_next SHALL equal pc_current.
REQ-017 Reset asserted in any state, mid-operation, SHALL abandon that state with no pulse emitted.

Configuration
REQ-018 The macro FAULT_RECOVERY_LOG_EN SHALL control logging.
  - Defined: fault_status is a sticky OR of fault_vec in every cycle, and fault_count increments (saturating at 16'hFFFF) once per NORMAL->SQUASH transition.
  - Undefined: fault_status and fault_count are tied to 0, no logging registers are built, and all other behaviour is identical.

Verification
REQ-019 The bench SHALL cover these scenarios (defaults, pc_current=0x10, pc_saved=0x08):
  - fault_vec=4'b0010 for 1 cycle -> that cycle writes 0 and nop=1; fault_cause=3'b101; 2 SQUASH cycles; 1 RETRY cycle with pc_next=0x08, retry_en=1; retry_count=1.
  - fault_vec=4'b1100 -> fault_cause=3'b110; fault_status=4'b1100 (LOG_EN).
  - 4 faults each separated by fewer than 8 clean cycles -> 3 RETRYs, then SAFE with safe_mode=1; resume_req -> 1-cycle resume_cpu, pc_next=0x08, retry_count=0.
  - 1 fault, then 8 clean NORMAL cycles -> retry_count returns to 0.
  - reset=0 asserted during SQUASH -> next cycle NORMAL, all counters 0, no retry_en.
  - resume_req in NORMAL and fault pulses during SAFE -> no state change; fault_count=1 after a single entry.
